// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: redirect input, instruction-memory read port and fetch-queue write port.
// Handshakes: imem_req is a one-cycle request strobe that is answered by exactly one imem_rvalid
// cycle at least one cycle later. fq_push is a one-cycle write strobe with no ready; the producer
// only pushes when fq_free was >= 4 at issue time. redirect_valid is a one-cycle strobe.
interface fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [5:0]  fq_free;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata0;
  logic [31:0] imem_rdata1;
  logic [31:0] imem_rdata2;
  logic [31:0] imem_rdata3;
  logic        imem_rvalid;
  logic        fq_push;
  logic [1:0]  fq_we;
  logic [63:0] fq_data0;
  logic [63:0] fq_data1;
  logic [63:0] fq_data2;
  logic [63:0] fq_data3;

  modport master (
    input  redirect_valid, redirect_pc, fq_free,
    input  imem_rdata0, imem_rdata1, imem_rdata2, imem_rdata3, imem_rvalid,
    output imem_req, imem_addr,
    output fq_push, fq_we, fq_data0, fq_data1, fq_data2, fq_data3
  );

  modport slave (
    output redirect_valid, redirect_pc, fq_free,
    output imem_rdata0, imem_rdata1, imem_rdata2, imem_rdata3, imem_rvalid,
    input  imem_req, imem_addr,
    input  fq_push, fq_we, fq_data0, fq_data1, fq_data2, fq_data3
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues 16-byte block reads and pushes the useful words of each block
// (from the fetch pc onwards) into the fetch queue, with redirect and in-flight drain handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      bus,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [1:0]  off;
  logic [31:0] rword [4];
  logic [63:0] entry [4];
  logic        unused_bits;

  assign fsm_state   = state;
  assign off         = req_pc[3:2];
  assign unused_bits = ^bus.redirect_pc[1:0];

  assign rword[0] = bus.imem_rdata0;
  assign rword[1] = bus.imem_rdata1;
  assign rword[2] = bus.imem_rdata2;
  assign rword[3] = bus.imem_rdata3;

  // Entry k carries the word at req_pc + 4k; entries past the end of the block are zero.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      entry[k] = '0;
      if (k < 4 - int'(off)) begin
        entry[k] = {req_pc + 32'(4 * k), rword[off + 2'(k)]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      req_pc       <= '0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
      bus.fq_push   <= 1'b0;
      bus.fq_we     <= '0;
      bus.fq_data0  <= '0;
      bus.fq_data1  <= '0;
      bus.fq_data2  <= '0;
      bus.fq_data3  <= '0;
    end else begin
      bus.imem_req <= 1'b0;
      bus.fq_push  <= 1'b0;
      if (bus.redirect_valid) begin
        pc <= {bus.redirect_pc[31:2], 2'b00};
      end
      case (state)
        FETCH: begin
          // Skip the cycle a push is still in flight so fq_free has caught up before issuing.
          if (!bus.redirect_valid && bus.fq_free >= 6'd4 && !bus.fq_push) begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= {pc[31:4], 4'b0000};
            req_pc        <= pc;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            state <= FETCH;
            if (!bus.redirect_valid) begin
              bus.fq_push  <= 1'b1;
              bus.fq_we    <= 2'd3 - off;
              bus.fq_data0 <= entry[0];
              bus.fq_data1 <= entry[1];
              bus.fq_data2 <= entry[2];
              bus.fq_data3 <= entry[3];
              pc           <= {req_pc[31:4], 4'b0000} + 32'd16;
            end
          end else if (bus.redirect_valid) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The stale response still has to arrive before a new request may go out.
          if (bus.imem_rvalid) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-004 The block SHALL provide port redirect_valid, input, 1 bit: branch or exception redirect strobe.
REQ-005 The block SHALL provide port redirect_pc, input, 32 bits: the redirect target.
REQ-006 The block SHALL provide port fq_free, input, 6 bits: the free entries reported by the downstream fetch queue (32-entry, 64-bit entries).
REQ-007 The block SHALL provide port imem_req, output, 1 bit: an instruction-memory read request, pulsed for one cycle.
REQ-008 The block SHALL provide port imem_addr, output, 32 bits: the fetch-block address, with [3:0] = 0.
REQ-009 The block SHALL provide ports imem_rdata0..3, input, 32 bits each: the four words of the 16-byte block.
REQ-010 The block SHALL provide port imem_rvalid, input, 1 bit: read data valid, at least 1 cycle after imem_req.
REQ-011 The block SHALL provide port fq_push, output, 1 bit: queue write strobe.
REQ-012 The block SHALL provide port fq_we, output, 2 bits: the entry count minus 1 (00 = 1 entry … 11 = 4 entries), matching the queue's encoding.
REQ-013 The block SHALL provide ports fq_data0..3, output, 64 bits each: {pc[31:0], instr[31:0]} per entry.

Function
REQ-014 The block SHALL hold a 32-bit pc register with pc[1:0] always 0; redirect_pc[1:0] is ignored.
REQ-015 The block SHALL implement a state machine with states FETCH, WAIT and DRAIN.
REQ-016 In FETCH, with no redirect_valid, fq_free >= 4 and fq_push = 0, the block SHALL assert imem_req with imem_addr = {pc[31:4], 4'b0}, latch req_pc = pc and go to WAIT.
REQ-017 In FETCH, when the condition of REQ-016 fails, the block SHALL not assert imem_req and SHALL stay in FETCH.
REQ-018 In WAIT, on imem_rvalid with no redirect_valid, the block SHALL register a push, set pc = {req_pc[31:4], 4'b0} + 16 and return to FETCH.
REQ-019 A registered push SHALL assert fq_push for exactly one cycle, in the cycle after imem_rvalid.
REQ-020 For each push, with n = 4 - req_pc[3:2], fq_we SHALL equal n - 1.
REQ-021 For each push, fq_dataK (K < n) SHALL equal {req_pc + 4K, imem_rdata[req_pc[3:2] + K]}, and fq_dataK (K >= n) SHALL be 0.
REQ-022 Outside a push cycle, fq_push SHALL be 0 and fq_data0..3 SHALL hold their last values.
REQ-023 pc arithmetic SHALL be modulo 2^32; 0xFFFF_FFF0 + 16 wraps to 0.
REQ-024 A redirect_valid in any state SHALL set pc = {redirect_pc[31:2], 2'b0} on the next edge.
REQ-025 A redirect in FETCH SHALL suppress imem_req in that cycle.
REQ-026 A redirect in WAIT without imem_rvalid SHALL move the state to DRAIN.
REQ-027 A redirect in WAIT with imem_rvalid SHALL discard the response, cause no push, and move the state to FETCH.
REQ-028 In DRAIN, imem_rvalid SHALL be discarded without a push and SHALL move the state to FETCH, even if redirect_valid is also high.
REQ-029 A redirect in DRAIN without imem_rvalid SHALL update pc and keep the state in DRAIN.
REQ-030 The block SHALL have at most one outstanding imem request at any time.
REQ-031 An imem_rvalid received in FETCH SHALL be ignored.
REQ-032 A push already registered (fq_push high) when redirect_valid arrives SHALL still complete; flushing the queue is the redirect source's job.

Reset
REQ-033 While rst_n = 0, the block SHALL force state = FETCH, pc = RESET_PC, req_pc = 0, imem_req = 0, imem_addr = 0, fq_push = 0, fq_we = 0 and fq_data0..3 = 0.
REQ-034 Reset SHALL take effect asynchronously, including mid-WAIT; a late imem_rvalid arriving after reset SHALL be ignored per REQ-031.
REQ-035 After reset deassertion, the first imem_req SHALL be possible on the first clk edge, with imem_addr = {RESET_PC[31:4], 4'b0}.

Verification
REQ-036 The bench SHALL cover reset release, RESET_PC = 0, fq_free = 32, words A/B/C/D returned 1 cycle later -> imem_addr = 0; fq_push with fq_we = 11 and data0..3 = {0,A}, {4,B}, {8,C}, {C,D}; next imem_addr = 0x10.
REQ-037 The bench SHALL cover redirect_pc = 0x0000_0109 -> imem_addr = 0x100; fq_we = 01; data0 = {0x108, rdata2}, data1 = {0x10C, rdata3}, data2..3 = 0; next imem_addr = 0x110.
REQ-038 The bench SHALL cover fq_free = 3 for 5 cycles, then raised to 4 -> no imem_req during the 5 cycles; imem_req in the cycle fq_free reads 4.
REQ-039 The bench SHALL cover redirect to 0x200 in WAIT with imem_rvalid 3 cycles later -> no fq_push; the next imem_req has imem_addr = 0x200, issued only after that imem_rvalid.
REQ-040 The bench SHALL cover redirect_valid coincident with imem_rvalid in WAIT -> no fq_push; next imem_addr = redirect target.
REQ-041 The bench SHALL cover pc = 0xFFFF_FFF0 with a full 4-entry fetch -> the next imem_addr is 0x0000_0000.
